vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Generates the VGA_Timing stream (pixel strobe, blanking, syncs, end-of-line/frame markers) consumed by the framebuffer video controller. Sits directly upstream of it, at the head of the video pipeline. It also provides a vblank interrupt with acknowledge, a frame counter and the current line number to the CPU register block.

Parameters:
PIX_DIV, 4, clk_i cycles per pixel (1..16)
H_VISIBLE, 320, visible pixels per line
H_FRONT, 8, horizontal front porch (pixels)
H_SYNC, 48, hsync width (pixels)
H_BACK, 24, horizontal back porch; H_TOTAL = 400
V_VISIBLE, 240, visible lines per frame
V_FRONT, 3, vertical front porch (lines)
V_SYNC, 4, vsync width (lines)
V_BACK, 15, vertical back porch; V_TOTAL = 262

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-high
en_i  in  1  timing enable; low holds the generator idle at pixel (0,0)
irq_ack_i  in  1  single-cycle pulse that clears vblank_irq_o
timing_o  out  VGA_Timing  valid, blank_n, hsync_n, vsync_n, end_of_line, end_of_frame
vblank_irq_o  out  1  sticky vblank interrupt
frame_cnt_o  out  16  completed-frame counter
line_o  out  10  v coordinate of the pixel most recently presented on timing_o

Behaviour:
- Reset (async, rst_i=1): div_cnt, h_cnt, v_cnt = 0.
  - timing_o: valid=0, blank_n=0, hsync_n=1, vsync_n=1, end_of_line=0, end_of_frame=0.
  - vblank_irq_o=0, frame_cnt_o=0, line_o=0.
- Disabled (en_i=0 sampled): on the next edge, counters are forced to 0 and timing_o goes to the idle value above. irq and frame counter hold.
  - This applies when en_i drops mid-line or mid-frame: restart is always at (0,0).
- Pixel tick: tick = en_i && div_cnt==PIX_DIV-1 (combinational).
  - div_cnt increments mod PIX_DIV while en_i=1.
  - If edge k is the first edge to sample en_i=1, the timing_o.valid for pixel (0,0) is registered at edge k+PIX_DIV-1.
  - Thereafter valid is a 1-clock pulse every PIX_DIV clocks. With PIX_DIV=1, valid is high continuously.
- Counters: these advance only on tick.
  - h_cnt wraps H_TOTAL-1 -> 0.
  - v_cnt increments when h_cnt wraps, and itself wraps V_TOTAL-1 -> 0.
- Output register: one clock latency. On a tick cycle for pixel (h,v), the next edge loads:
  - blank_n = (h<H_VISIBLE) && (v<V_VISIBLE)
  - hsync_n = !(H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC)
  - vsync_n = !(V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC)
  - end_of_line = (h==H_VISIBLE), on every line including vblank lines
  - end_of_frame = (h==H_VISIBLE && v==V_VISIBLE-1)
  - line_o = v
- Non-tick cycles: valid=0, end_of_line=0, end_of_frame=0. blank_n, hsync_n, vsync_n and line_o hold their previous values.
  - end_of_* are therefore exactly one clock wide and always coincide with valid=1.
- Interrupt: vblank_irq_o is set on the edge that registers end_of_frame=1 and cleared on the edge sampling irq_ack_i=1.
  - Set and ack on the same edge: set wins (irq stays 1).
  - Ack while already clear: no effect.
- frame_cnt_o increments on the same edge as the irq set and wraps 0xFFFF -> 0x0000.
- Width rules: h_cnt/v_cnt are 10 bits. Elaboration fails if H_TOTAL>1024, V_TOTAL>1024, PIX_DIV<1 or any porch/sync parameter is 0.

Decomposition:
- The VGA_Timing struct stays in the shared VGA_Timing definition.
- Add a video_pkg holding mode localparams (H_*/V_* for the 320x240 mode) and a VGA_TIMING_IDLE constant, so consumers reset to the same idle value.
- One natural sub-module: video_pix_div, the clock-enable divider producing tick from en_i.

Test Plan:
- Reset and disabled: assert rst_i mid-frame, then hold en_i=0 for 100 clocks -> timing_o idle (valid=0, blank_n=0, hsync_n=1, vsync_n=1), irq=0, frame_cnt_o=0.
- Enable start: en_i rises, sampled at edge k -> first valid at edge k+3 with blank_n=1, line_o=0; subsequent valids are spaced exactly 4 clocks apart.
- Line timing: valid pixels 0..319 have blank_n=1 -> pixel 320 carries end_of_line=1, blank_n=0. hsync_n=0 for pixels 328..375 only. Line period is 1600 clocks.
- Frame timing: end_of_frame exactly once per 104800 valids, on line 239 pixel 320. vsync_n=0 on lines 243..246. Lines 240..261 have blank_n=0 but still carry end_of_line. irq=1 and frame_cnt_o=1 after frame 1.
- IRQ handshake: pulse irq_ack_i on the same edge as end_of_frame -> irq stays 1. A later lone ack -> irq 0. Preload frame_cnt_o at 0xFFFF -> next frame gives 0x0000.
- en_i drop mid-line (h=150, v=100), re-raise 10 clocks later -> idle on the next edge, then restart at (0,0) with the start latency above. irq and frame_cnt_o are unchanged.

Source files
------------

// File: rtl/video_pkg.sv
// video_pkg: shared VGA timing stream type, idle value and 320x240 mode constants
//   vga_timing_t    : valid, blank_n, hsync_n, vsync_n, end_of_line, end_of_frame
//   VGA_TIMING_IDLE : value every producer/consumer of the stream resets to
package video_pkg;
  typedef struct packed {
    logic valid;
    logic blank_n;
    logic hsync_n;
    logic vsync_n;
    logic end_of_line;
    logic end_of_frame;
  } vga_timing_t;
  localparam vga_timing_t VGA_TIMING_IDLE = '{
    valid: 1'b0, blank_n: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1,
    end_of_line: 1'b0, end_of_frame: 1'b0
  };
  localparam int PIX_DIV   = 4;
  localparam int H_VISIBLE = 320;
  localparam int H_FRONT   = 8;
  localparam int H_SYNC    = 48;
  localparam int H_BACK    = 24;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_VISIBLE = 240;
  localparam int V_FRONT   = 3;
  localparam int V_SYNC    = 4;
  localparam int V_BACK    = 15;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
endpackage

// File: rtl/video_pix_div.sv
// video_pix_div: pixel clock-enable divider, one tick every PIX_DIV clocks while enabled
//   clk_i, rst_i : clock, async active-high reset
//   en_i         : enable; low clears the divider so the first tick is PIX_DIV-1 clocks after enable
//   tick_o       : combinational pixel strobe
module video_pix_div #(
  parameter int PIX_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);
  localparam int DW = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
  logic [DW-1:0] div_cnt;
  assign tick_o = en_i && div_cnt == DW'(PIX_DIV - 1);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) div_cnt <= '0;
    else div_cnt <= (!en_i || tick_o) ? '0 : div_cnt + DW'(1);
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA timing stream generator with vblank interrupt, frame counter and line number
//   clk_i, rst_i  : clock, async active-high reset
//   en_i          : timing enable; low parks the raster at pixel (0,0) with an idle stream
//   irq_ack_i     : one-cycle pulse clearing vblank_irq_o
//   timing_o      : registered timing stream, one clock after the pixel tick
//   vblank_irq_o  : sticky, set when end_of_frame is presented
//   frame_cnt_o   : completed-frame counter, wraps at 16 bits
//   line_o        : v coordinate of the last presented pixel
module vga_timing_gen
  import video_pkg::vga_timing_t, video_pkg::VGA_TIMING_IDLE;
#(
  parameter int PIX_DIV   = video_pkg::PIX_DIV,
  parameter int H_VISIBLE = video_pkg::H_VISIBLE,
  parameter int H_FRONT   = video_pkg::H_FRONT,
  parameter int H_SYNC    = video_pkg::H_SYNC,
  parameter int H_BACK    = video_pkg::H_BACK,
  parameter int V_VISIBLE = video_pkg::V_VISIBLE,
  parameter int V_FRONT   = video_pkg::V_FRONT,
  parameter int V_SYNC    = video_pkg::V_SYNC,
  parameter int V_BACK    = video_pkg::V_BACK
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        irq_ack_i,
  output vga_timing_t timing_o,
  output logic        vblank_irq_o,
  output logic [15:0] frame_cnt_o,
  output logic [9:0]  line_o
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  if (H_TOTAL > 1024 || V_TOTAL > 1024 || PIX_DIV < 1 || PIX_DIV > 16 ||
      H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_params
    $error("vga_timing_gen: invalid timing parameters");
  end
  localparam logic [9:0] HV   = 10'(H_VISIBLE);
  localparam logic [9:0] HS0  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS1  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] HL   = 10'(H_TOTAL - 1);
  localparam logic [9:0] VV   = 10'(V_VISIBLE);
  localparam logic [9:0] VVL  = 10'(V_VISIBLE - 1);
  localparam logic [9:0] VS0  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS1  = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] VL   = 10'(V_TOTAL - 1);
  logic       tick;
  logic [9:0] h_cnt, v_cnt;
  logic       eol, irq_set;
  video_pix_div #(.PIX_DIV(PIX_DIV)) u_pix_div (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (en_i),
    .tick_o (tick)
  );
  assign eol     = h_cnt == HV;
  assign irq_set = tick && eol && v_cnt == VVL;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      h_cnt        <= '0;
      v_cnt        <= '0;
      timing_o     <= VGA_TIMING_IDLE;
      vblank_irq_o <= 1'b0;
      frame_cnt_o  <= '0;
      line_o       <= '0;
    end else begin
      if (!en_i) begin
        h_cnt    <= '0;
        v_cnt    <= '0;
        timing_o <= VGA_TIMING_IDLE;
      end else begin
        timing_o.valid        <= tick;
        timing_o.end_of_line  <= tick && eol;
        timing_o.end_of_frame <= irq_set;
        if (tick) begin
          timing_o.blank_n <= h_cnt < HV && v_cnt < VV;
          timing_o.hsync_n <= !(h_cnt >= HS0 && h_cnt < HS1);
          timing_o.vsync_n <= !(v_cnt >= VS0 && v_cnt < VS1);
          line_o           <= v_cnt;
          h_cnt            <= h_cnt == HL ? '0 : h_cnt + 10'd1;
          if (h_cnt == HL) v_cnt <= v_cnt == VL ? '0 : v_cnt + 10'd1;
        end
      end
      // a new frame end outranks an ack arriving on the same edge
      if (irq_set) begin
        vblank_irq_o <= 1'b1;
        frame_cnt_o  <= frame_cnt_o + 16'd1;
      end else if (irq_ack_i) begin
        vblank_irq_o <= 1'b0;
      end
    end
endmodule
